// File: rtl/hb_link_req_arbiter.sv
// Credit-managed round-robin arbiter sharing one forward-link endpoint among
// num_req_p requesters, with in-order response routing back to the issuer.
module hb_link_req_arbiter #(
    parameter int num_req_p      = 3,
    parameter int packet_width_p = 128,
    parameter int rsp_width_p    = 32,
    parameter int credits_p      = 32
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  en_i,
    input  logic [num_req_p-1:0]                  req_v_i,
    input  logic [num_req_p*packet_width_p-1:0]   req_data_i,
    output logic [num_req_p-1:0]                  req_yumi_o,
    output logic                                  pkt_v_o,
    output logic [packet_width_p-1:0]             pkt_data_o,
    input  logic                                  pkt_ready_i,
    input  logic                                  rsp_v_i,
    input  logic [rsp_width_p-1:0]                rsp_data_i,
    output logic                                  rsp_ready_o,
    output logic [num_req_p-1:0]                  rsp_v_o,
    output logic [rsp_width_p-1:0]                rsp_data_o,
    input  logic [num_req_p-1:0]                  rsp_ready_i,
    output logic [$clog2(credits_p+1)-1:0]        credits_o,
    output logic                                  idle_o
);
    localparam int id_w   = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cred_w = $clog2(credits_p + 1);
    localparam int ptr_w  = (credits_p > 1) ? $clog2(credits_p) : 1;

    logic [num_req_p-1:0][packet_width_p-1:0] req_data_a;
    logic [id_w-1:0]   ptr_r, lock_id_r, scan_id, idx_v, gnt_id, head_id;
    logic              lock_r, found, eligible, fwd_hs, rsp_hs;
    logic [cred_w-1:0] credits_r, fifo_cnt_r;
    logic [ptr_w-1:0]  wr_ptr_r, rd_ptr_r;
    logic [id_w-1:0]   fifo_mem [credits_p];
    logic              fifo_empty, fifo_full;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(credits_p - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [id_w-1:0] id_inc(input logic [id_w-1:0] id);
        return (id == id_w'(num_req_p - 1)) ? '0 : id + 1'b1;
    endfunction

    assign req_data_a = req_data_i;
    assign fifo_empty = (fifo_cnt_r == '0);
    assign fifo_full  = (fifo_cnt_r == cred_w'(credits_p));
    assign eligible   = (credits_r != '0) && !fifo_full;

    // Round-robin scan starting at ptr_r, wrapping past the last requester.
    always_comb begin
        found   = 1'b0;
        scan_id = '0;
        idx_v   = '0;
        for (int k = 0; k < num_req_p; k++) begin
            idx_v = id_w'((int'(ptr_r) + k) % num_req_p);
            if (!found && req_v_i[idx_v]) begin
                found   = 1'b1;
                scan_id = idx_v;
            end
        end
    end

    // A packet offered under backpressure stays pinned until it is taken,
    // independent of en_i, so drain never strands a half-presented packet.
    assign gnt_id     = lock_r ? lock_id_r : scan_id;
    assign pkt_v_o    = lock_r ? req_v_i[lock_id_r] : (en_i && eligible && found);
    assign pkt_data_o = req_data_a[gnt_id];
    assign fwd_hs     = pkt_v_o && pkt_ready_i;
    assign req_yumi_o = fwd_hs ? (num_req_p'(1) << gnt_id) : '0;

    assign head_id     = fifo_mem[rd_ptr_r];
    assign rsp_v_o     = (rsp_v_i && !fifo_empty) ? (num_req_p'(1) << head_id) : '0;
    assign rsp_ready_o = !fifo_empty && rsp_ready_i[head_id];
    assign rsp_data_o  = rsp_data_i;
    assign rsp_hs      = rsp_v_i && rsp_ready_o;

    assign credits_o = credits_r;
    assign idle_o    = fifo_empty && !lock_r;

    always_ff @(posedge clk_i) begin
        if (fwd_hs)
            fifo_mem[wr_ptr_r] <= gnt_id;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r      <= '0;
            lock_r     <= 1'b0;
            lock_id_r  <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
            credits_r  <= cred_w'(credits_p);
        end else begin
            if (fwd_hs) begin
                ptr_r    <= id_inc(gnt_id);
                wr_ptr_r <= ptr_inc(wr_ptr_r);
                lock_r   <= 1'b0;
            end else if (pkt_v_o) begin
                lock_r    <= 1'b1;
                lock_id_r <= gnt_id;
            end
            if (rsp_hs)
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({fwd_hs, rsp_hs})
                2'b10: begin
                    fifo_cnt_r <= fifo_cnt_r + 1'b1;
                    credits_r  <= credits_r - 1'b1;
                end
                2'b01: begin
                    fifo_cnt_r <= fifo_cnt_r - 1'b1;
                    credits_r  <= credits_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A response with nothing outstanding is ignored (rsp_ready_o stays low).
    rsp_without_req: assert property (@(posedge clk_i) disable iff (reset_i)
                                      !(rsp_v_i && fifo_empty));
endmodule

// File: tb/tb_hb_link_req_arbiter.sv
// Directed bench for hb_link_req_arbiter with 3 requesters and 4 credits.
module tb_hb_link_req_arbiter;
    localparam int N  = 3;
    localparam int PW = 128;
    localparam int RW = 32;
    localparam int CR = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [N-1:0]     req_v;
    logic [N*PW-1:0]  req_data;
    logic [N-1:0]     req_yumi;
    logic             pkt_v;
    logic [PW-1:0]    pkt_data;
    logic             pkt_ready;
    logic             rsp_v;
    logic [RW-1:0]    rsp_data;
    logic             rsp_ready_o;
    logic [N-1:0]     rsp_v_o;
    logic [RW-1:0]    rsp_data_o;
    logic [N-1:0]     rsp_ready;
    logic [2:0]       credits;
    logic             idle;

    int checks = 0;
    int errors = 0;

    hb_link_req_arbiter #(.num_req_p(N), .packet_width_p(PW), .rsp_width_p(RW), .credits_p(CR)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en),
        .req_v_i(req_v), .req_data_i(req_data), .req_yumi_o(req_yumi),
        .pkt_v_o(pkt_v), .pkt_data_o(pkt_data), .pkt_ready_i(pkt_ready),
        .rsp_v_i(rsp_v), .rsp_data_i(rsp_data), .rsp_ready_o(rsp_ready_o),
        .rsp_v_o(rsp_v_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready),
        .credits_o(credits), .idle_o(idle)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] dat(input int i);
        return {32'hC0DE_0000 + i, 96'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; req_v = '0; pkt_ready = 1'b1;
        rsp_v = 1'b0; rsp_data = '0; rsp_ready = '1;
        for (int i = 0; i < N; i++) req_data[i*PW +: PW] = dat(i);
        tick(); tick();
        reset = 1'b0;
        settle();
        chk("rst_pkt_v", pkt_v, 0);
        chk("rst_yumi", req_yumi, 0);
        chk("rst_rsp_v", rsp_v_o, 0);
        chk("rst_rsp_ready", rsp_ready_o, 0);
        chk("rst_idle", idle, 1);
        chk("rst_credits", credits, CR);

        // Fairness with concurrent responses: push+pop keeps credits at 3.
        for (int k = 0; k < 6; k++) begin
            req_v = 3'b111;
            rsp_v = (k > 0);
            rsp_data = 32'h5000 + k;
            settle();
            chk("fair_yumi", req_yumi, 3'b001 << (k % 3));
            chk("fair_data", pkt_data, dat(k % 3));
            chk("fair_credits", credits, (k == 0) ? 4 : 3);
            if (k > 0) begin
                chk("fair_rsp_v", rsp_v_o, 3'b001 << ((k - 1) % 3));
                chk("fair_rsp_rdy", rsp_ready_o, 1);
                chk("fair_rsp_data", rsp_data_o, 32'h5000 + k);
            end
            tick();
        end
        req_v = '0;
        settle();
        chk("fair_tail_yumi", req_yumi, 0);
        chk("fair_tail_rsp_v", rsp_v_o, 3'b100);
        chk("fair_tail_credits", credits, 3);
        tick();
        rsp_v = 1'b0;
        settle();
        chk("fair_end_credits", credits, 4);
        chk("fair_end_idle", idle, 1);

        // Lock under backpressure: req1 pinned while req0 also asks.
        pkt_ready = 1'b0;
        req_v = 3'b010;
        settle();
        chk("lock_pkt_v", pkt_v, 1);
        chk("lock_data0", pkt_data, dat(1));
        chk("lock_yumi0", req_yumi, 0);
        tick();
        req_v = 3'b011;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("lock_data", pkt_data, dat(1));
            chk("lock_yumi", req_yumi, 0);
            chk("lock_idle", idle, 0);
            tick();
        end
        pkt_ready = 1'b1;
        settle();
        chk("lock_release_yumi", req_yumi, 3'b010);
        tick();
        settle();
        chk("lock_next_yumi", req_yumi, 3'b001);
        chk("lock_next_data", pkt_data, dat(0));
        tick();
        req_v = '0; rsp_v = 1'b1;
        settle();
        chk("lock_rsp0", rsp_v_o, 3'b010);
        tick();
        settle();
        chk("lock_rsp1", rsp_v_o, 3'b001);
        tick();
        rsp_v = 1'b0;
        settle();
        chk("lock_end_credits", credits, 4);

        // Credit exhaustion: ptr=1, grants 1,2,0,1 then stop.
        req_v = 3'b111;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("cred_yumi", req_yumi, 3'b001 << ((k + 1) % 3));
            tick();
        end
        settle();
        chk("cred_empty_pkt_v", pkt_v, 0);
        chk("cred_empty_credits", credits, 0);
        tick();
        settle();
        chk("cred_hold_pkt_v", pkt_v, 0);
        rsp_v = 1'b1; rsp_data = 32'h0000_00F1;
        settle();
        chk("cred_ret_rsp_v", rsp_v_o, 3'b010);
        chk("cred_ret_pkt_v", pkt_v, 0);
        tick();
        rsp_v = 1'b0;
        settle();
        chk("cred_one_credits", credits, 1);
        chk("cred_fifth_yumi", req_yumi, 3'b100);
        tick();
        req_v = '0;
        settle();
        chk("cred_refill_credits", credits, 0);

        // Response routing: queue holds 2,0,1,2.
        rsp_v = 1'b1; rsp_data = 32'hAAAA_AAAA;
        settle();
        chk("route_A_v", rsp_v_o, 3'b100);
        chk("route_A_data", rsp_data_o, 32'hAAAA_AAAA);
        tick();
        rsp_data = 32'hBBBB_BBBB;
        settle();
        chk("route_B_v", rsp_v_o, 3'b001);
        chk("route_B_data", rsp_data_o, 32'hBBBB_BBBB);
        tick();
        rsp_data = 32'hCCCC_CCCC; rsp_ready = 3'b011;
        settle();
        chk("route_C_v", rsp_v_o, 3'b010);
        chk("route_C_rdy", rsp_ready_o, 1);
        tick();
        rsp_data = 32'hDDDD_DDDD;
        settle();
        chk("route_D_v", rsp_v_o, 3'b100);
        chk("route_D_stall", rsp_ready_o, 0);
        chk("route_D_credits", credits, 3);
        tick();
        settle();
        chk("route_D_still_v", rsp_v_o, 3'b100);
        chk("route_D_still_credits", credits, 3);
        rsp_ready = 3'b111;
        settle();
        chk("route_D_rdy", rsp_ready_o, 1);
        chk("route_D_data", rsp_data_o, 32'hDDDD_DDDD);
        tick();
        rsp_v = 1'b0;
        settle();
        chk("route_end_credits", credits, 4);
        chk("route_end_idle", idle, 1);

        // Drain: two outstanding, then req0 locked when en drops.
        req_v = 3'b110;
        settle();
        chk("drain_g1", req_yumi, 3'b010);
        tick();
        settle();
        chk("drain_g2", req_yumi, 3'b100);
        tick();
        req_v = 3'b001; pkt_ready = 1'b0;
        settle();
        chk("drain_lock_yumi", req_yumi, 0);
        tick();
        en = 1'b0; req_v = 3'b111;
        settle();
        chk("drain_locked_v", pkt_v, 1);
        chk("drain_locked_data", pkt_data, dat(0));
        chk("drain_locked_idle", idle, 0);
        pkt_ready = 1'b1;
        settle();
        chk("drain_complete_yumi", req_yumi, 3'b001);
        tick();
        req_v = 3'b110;
        settle();
        chk("drain_no_grant", pkt_v, 0);
        chk("drain_credits", credits, 1);
        rsp_v = 1'b1;
        settle();
        chk("drain_rsp0", rsp_v_o, 3'b010);
        tick();
        settle();
        chk("drain_rsp1", rsp_v_o, 3'b100);
        chk("drain_still_no_grant", pkt_v, 0);
        tick();
        settle();
        chk("drain_rsp2", rsp_v_o, 3'b001);
        chk("drain_last_idle", idle, 0);
        tick();
        rsp_v = 1'b0;
        settle();
        chk("drain_idle", idle, 1);
        chk("drain_idle_pkt_v", pkt_v, 0);
        en = 1'b1;
        settle();
        chk("resume_yumi", req_yumi, 3'b010);
        tick();
        req_v = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
